// File: rtl/clk_enable_nco.sv
// clk_enable_nco: multi-channel phase-accumulator clock-enable generator with a PLL-style lock flag.
// Optional build macro CLK_ENABLE_NCO_PHASE_ALIGN_EN: every apply restarts all channels phase-aligned.
module clk_enable_nco #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic                cfg_en,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] outclk,
    output logic                locked
);
    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        RUN    = 2'd1,
        APPLY  = 2'd2
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(LOCK_CYCLES - 1);

    state_t            state_reg;
    logic [15:0]       settle_cnt_reg;
    logic              ready_reg;
    logic              locked_reg;
    logic [CH_W-1:0]   cap_chan_reg;
    logic [ACC_W-1:0]  cap_inc_reg;
    logic              cap_en_reg;
    logic              chan_ok;
    logic              xfer;
    logic              apply;

    // Out-of-range channel indices are only possible when CHANNELS is not a power of two.
    generate
        if ((1 << CH_W) == CHANNELS) begin : g_full_range
            assign chan_ok = 1'b1;
        end else begin : g_partial_range
            assign chan_ok = (32'(cfg_chan) < 32'(CHANNELS));
        end
    endgenerate

    assign xfer      = cfg_valid && ready_reg && chan_ok;
    assign apply     = (state_reg == APPLY);
    assign cfg_ready = ready_reg;
    assign locked    = locked_reg;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg      <= SETTLE;
            settle_cnt_reg <= '0;
            ready_reg      <= 1'b1;
            locked_reg     <= 1'b0;
            cap_chan_reg   <= '0;
            cap_inc_reg    <= '0;
            cap_en_reg     <= 1'b0;
        end else begin
            case (state_reg)
                SETTLE: begin
                    if (xfer) begin
                        state_reg    <= APPLY;
                        ready_reg    <= 1'b0;
                        locked_reg   <= 1'b0;
                        cap_chan_reg <= cfg_chan;
                        cap_inc_reg  <= cfg_inc;
                        cap_en_reg   <= cfg_en;
                    end else if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg  <= RUN;
                        locked_reg <= 1'b1;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 16'd1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        state_reg    <= APPLY;
                        ready_reg    <= 1'b0;
                        locked_reg   <= 1'b0;
                        cap_chan_reg <= cfg_chan;
                        cap_inc_reg  <= cfg_inc;
                        cap_en_reg   <= cfg_en;
                    end
                end
                APPLY: begin
                    state_reg      <= SETTLE;
                    settle_cnt_reg <= '0;
                    ready_reg      <= 1'b1;
                end
                default: begin
                    state_reg      <= SETTLE;
                    settle_cnt_reg <= '0;
                    ready_reg      <= 1'b1;
                    locked_reg     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [ACC_W-1:0] acc_reg;
        logic [ACC_W-1:0] inc_reg;
        logic             en_reg;
        logic             tick_reg;
        logic             outclk_reg;
        logic [ACC_W:0]   sum;
        logic             hit;

        // Extra top bit of the sum is the wrap carry that becomes the tick.
        assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};
        assign hit = apply && (cap_chan_reg == CH_W'(gi));

        always_ff @(posedge refclk) begin
            if (rst) begin
                acc_reg    <= '0;
                inc_reg    <= '0;
                en_reg     <= 1'b0;
                tick_reg   <= 1'b0;
                outclk_reg <= 1'b0;
            end else begin
                if (en_reg) begin
                    acc_reg    <= sum[ACC_W-1:0];
                    tick_reg   <= sum[ACC_W];
                    outclk_reg <= sum[ACC_W-1];
                end else begin
                    acc_reg    <= '0;
                    tick_reg   <= 1'b0;
                    outclk_reg <= 1'b0;
                end
`ifdef CLK_ENABLE_NCO_PHASE_ALIGN_EN
                if (apply) begin
                    acc_reg    <= '0;
                    tick_reg   <= 1'b0;
                    outclk_reg <= 1'b0;
                end
`endif
                if (hit) begin
                    inc_reg <= cap_inc_reg;
                    en_reg  <= cap_en_reg;
                end
            end
        end

        assign tick[gi]   = tick_reg;
        assign outclk[gi] = outclk_reg;
    end

endmodule

// File: tb/tb_clk_enable_nco.sv
// Directed bench for clk_enable_nco (CHANNELS=2, ACC_W=8, LOCK_CYCLES=4) plus a 3-channel
// instance that can receive an out-of-range channel index.
module tb_clk_enable_nco;
    logic       refclk = 1'b0;
    logic       rst    = 1'b1;

    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [0:0] cfg_chan  = 1'b0;
    logic [7:0] cfg_inc   = 8'd0;
    logic       cfg_en    = 1'b0;
    logic [1:0] tick;
    logic [1:0] outclk;
    logic       locked;

    logic       b_cfg_valid = 1'b0;
    logic       b_cfg_ready;
    logic [1:0] b_cfg_chan  = 2'd0;
    logic [7:0] b_cfg_inc   = 8'd0;
    logic       b_cfg_en    = 1'b0;
    logic [2:0] b_tick;
    logic [2:0] b_outclk;
    logic       b_locked;

    int n_checks = 0;
    int n_pass   = 0;
    int last;
    int cnt0;
    int cnt1;
    int n1;
    logic exp_t;
    logic exp_o;
    logic found;

    always #5 refclk = ~refclk;

    clk_enable_nco #(.CHANNELS(2), .ACC_W(8), .LOCK_CYCLES(4)) dut (
        .refclk(refclk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_inc(cfg_inc), .cfg_en(cfg_en),
        .tick(tick), .outclk(outclk), .locked(locked)
    );

    clk_enable_nco #(.CHANNELS(3), .ACC_W(8), .LOCK_CYCLES(4)) dut_b (
        .refclk(refclk), .rst(rst),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_chan(b_cfg_chan),
        .cfg_inc(b_cfg_inc), .cfg_en(b_cfg_en),
        .tick(b_tick), .outclk(b_outclk), .locked(b_locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge refclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values and the lock sequence after release.
        rst = 1'b1;
        repeat (3) cycle();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_outclk", 32'(outclk), 32'd0);
        check("rst_b_ready", 32'(b_cfg_ready), 32'd1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("lock_after_reset", 32'(locked), 32'(k == 3));
            check("idle_tick", 32'(tick), 32'd0);
            check("idle_outclk", 32'(outclk), 32'd0);
        end

        // ch0 inc=64: tick every 4, outclk 2 high / 2 low, relock after LOCK_CYCLES+1 edges.
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_inc = 8'd64; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        check("apply_ready", 32'(cfg_ready), 32'd0);
        check("apply_locked", 32'(locked), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (k == 1) check("ready_after_apply", 32'(cfg_ready), 32'd1);
            if (k <= 6) check("ch0_relock", 32'(locked), 32'(k >= 5));
            exp_t = (k >= 2) && ((k - 1) % 4 == 0);
            exp_o = (k >= 2) && ((k - 1) % 4 >= 2);
            check("ch0_tick", 32'(tick[0]), 32'(exp_t));
            check("ch0_outclk", 32'(outclk[0]), 32'(exp_o));
            check("ch1_idle", 32'({tick[1], outclk[1]}), 32'd0);
        end

        // ch1 inc=85: 85 ticks per 256 cycles, gaps of 3 or 4.
        cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_inc = 8'd85; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        repeat (10) cycle();
        last = -1; cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (tick[1]) begin
                if (last >= 0) check("ch1_gap_3_or_4", 32'((i - last == 3) || (i - last == 4)), 32'd1);
                last = i;
                cnt1++;
            end
            if (tick[0]) cnt0++;
        end
        check("ch1_ticks_256", 32'(cnt1), 32'd85);
        check("ch0_ticks_256", 32'(cnt0), 32'd64);

        // Back-to-back: valid held high, ready drops for one cycle, second request wins.
        cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_inc = 8'd16; cfg_en = 1'b1;
        cycle();
        check("b2b_ready_a", 32'(cfg_ready), 32'd0);
        cfg_inc = 8'd32;
        cycle();
        check("b2b_ready_gap", 32'(cfg_ready), 32'd1);
        cycle();
        cfg_valid = 1'b0;
        check("b2b_ready_b", 32'(cfg_ready), 32'd0);
        cycle();
        check("b2b_ready_done", 32'(cfg_ready), 32'd1);
        last = -1; n1 = 0;
        for (int i = 0; i < 48; i++) begin
            cycle();
            if (tick[1]) begin
                if (last >= 0) check("ch1_gap_8", 32'(i - last), 32'd8);
                last = i;
                n1++;
            end
        end
        check("ch1_ticks_48", 32'(n1), 32'd6);

        // Reprogram ch1 to 64 right after a ch0 tick.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            if (tick[0]) found = 1'b1;
        end
        check("sync_ch0", 32'(found), 32'd1);
        cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_inc = 8'd64; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        check("reprog_locked", 32'(locked), 32'd0);
        check("reprog_ch0_tick_k1", 32'(tick[0]), 32'd0);
        check("reprog_ch0_outclk_k1", 32'(outclk[0]), 32'd0);
        n1 = 0;
        for (int k = 2; k <= 20; k++) begin
            cycle();
`ifdef CLK_ENABLE_NCO_PHASE_ALIGN_EN
            exp_t = (k >= 6) && ((k - 2) % 4 == 0);
            exp_o = ((k - 2) % 4 >= 2);
            check("align_ch0_tick", 32'(tick[0]), 32'(exp_t));
            check("align_ch0_outclk", 32'(outclk[0]), 32'(exp_o));
            check("align_ch1_tick", 32'(tick[1]), 32'(exp_t));
            check("align_ch1_outclk", 32'(outclk[1]), 32'(exp_o));
`else
            exp_t = (k % 4 == 0);
            exp_o = (k % 4 >= 2);
            check("keep_ch0_tick", 32'(tick[0]), 32'(exp_t));
            check("keep_ch0_outclk", 32'(outclk[0]), 32'(exp_o));
            if (k >= 5 && tick[1]) n1++;
`endif
        end
`ifndef CLK_ENABLE_NCO_PHASE_ALIGN_EN
        check("ch1_ticks_new_inc", 32'(n1), 32'd4);
`endif

        // Out-of-range channel on the 3-channel instance: acknowledged and dropped.
        b_cfg_valid = 1'b1; b_cfg_chan = 2'd0; b_cfg_inc = 8'd64; b_cfg_en = 1'b1;
        cycle();
        b_cfg_valid = 1'b0;
        repeat (8) cycle();
        check("b_locked_before_drop", 32'(b_locked), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            if (b_tick[0]) found = 1'b1;
        end
        check("sync_b_ch0", 32'(found), 32'd1);
        b_cfg_valid = 1'b1; b_cfg_chan = 2'd3; b_cfg_inc = 8'd200; b_cfg_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            b_cfg_valid = 1'b0;
            check("drop_ready", 32'(b_cfg_ready), 32'd1);
            check("drop_locked", 32'(b_locked), 32'd1);
            check("drop_ch0_tick", 32'(b_tick[0]), 32'(k % 4 == 0));
            check("drop_ch0_outclk", 32'(b_outclk[0]), 32'(k % 4 >= 2));
            check("drop_others", 32'({b_tick[2:1], b_outclk[2:1]}), 32'd0);
        end

        // inc = 2^ACC_W-1 on b ch1: tick every cycle except the first after the clear.
        b_cfg_valid = 1'b1; b_cfg_chan = 2'd1; b_cfg_inc = 8'd255; b_cfg_en = 1'b1;
        cycle();
        b_cfg_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("max_inc_tick", 32'(b_tick[1]), 32'(k >= 3));
            check("max_inc_outclk", 32'(b_outclk[1]), 32'(k >= 2));
        end

        // inc = 0 with en = 1 on b ch2: never ticks, outclk stays low.
        b_cfg_valid = 1'b1; b_cfg_chan = 2'd2; b_cfg_inc = 8'd0; b_cfg_en = 1'b1;
        cycle();
        b_cfg_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("zero_inc_ch2", 32'({b_tick[2], b_outclk[2]}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
